// File: rtl/cmos_bf.sv
// cmos_bf: switch-level model of a fault-injectable CMOS gate, Y = ~((A&B)|C), plus a clocked monitor
module cmos_bf #(
   parameter logic [5:0] STUCK_OPEN = 6'b000000,
   parameter logic [5:0] STUCK_ON   = 6'b000000,
   parameter int         CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             A,
   input  logic             B,
   input  logic             C,
   output logic             Y,
   output logic             y_q,
   output logic             pun_on,
   output logic             pdn_on,
   output logic             float_seen,
   output logic             contention_seen,
   output logic [CNT_W-1:0] mismatch_cnt
);
   logic [5:0] nominal;
   logic [5:0] on;
   logic       y_hold;
   logic       driven;
   logic       golden;
   // bit order: nA nB nC pA pB pC; open beats stuck-on
   assign nominal = {~C, ~B, ~A, C, B, A};
   assign on      = ~STUCK_OPEN & (STUCK_ON | nominal);
   assign pdn_on  = (on[0] & on[1]) | on[2];
   assign pun_on  = on[5] & (on[3] | on[4]);
   assign driven  = pun_on | pdn_on;
   assign golden  = ~((A & B) | C);
   assign Y       = driven ? !pdn_on : y_hold;
   // charge retention on the output node; a driven value wins over reset
   always_latch begin
      if (driven) y_hold <= !pdn_on;
      else if (!rst_n) y_hold <= 1'b0;
   end
   // monitor: registered output, sticky fault flags, saturating mismatch count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q             <= 1'b0;
         float_seen      <= 1'b0;
         contention_seen <= 1'b0;
         mismatch_cnt    <= '0;
      end else begin
         y_q             <= Y;
         float_seen      <= float_seen | (!pun_on & !pdn_on);
         contention_seen <= contention_seen | (pun_on & pdn_on);
         if (Y != golden && !(&mismatch_cnt)) mismatch_cnt <= mismatch_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_cmos_bf.sv
// tb_cmos_bf: randomized check of four fault configurations against a transistor-level reference model
module tb_cmos_bf;
   localparam logic [5:0] OPN [4] = '{6'b000000, 6'b000100, 6'b000000, 6'b000100};
   localparam logic [5:0] SON [4] = '{6'b000000, 6'b000000, 6'b001000, 6'b000000};
   localparam int         MAXC [4] = '{65535, 65535, 65535, 15};
   logic clk, rst_n, A, B, C;
   logic [3:0] y, yq, pun, pdn, fs, cs;
   logic [15:0] cnt0, cnt1, cnt2;
   logic [3:0] cnt3;
   int tests, fails;
   logic m_pu [4], m_pd [4], m_hold [4], m_y [4], m_yq [4], m_fs [4], m_cs [4];
   int m_cnt [4];

   cmos_bf u0 (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .Y(y[0]), .y_q(yq[0]), .pun_on(pun[0]),
               .pdn_on(pdn[0]), .float_seen(fs[0]), .contention_seen(cs[0]), .mismatch_cnt(cnt0));
   cmos_bf #(.STUCK_OPEN(6'b000100)) u1 (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .Y(y[1]),
               .y_q(yq[1]), .pun_on(pun[1]), .pdn_on(pdn[1]), .float_seen(fs[1]), .contention_seen(cs[1]),
               .mismatch_cnt(cnt1));
   cmos_bf #(.STUCK_ON(6'b001000)) u2 (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .Y(y[2]),
               .y_q(yq[2]), .pun_on(pun[2]), .pdn_on(pdn[2]), .float_seen(fs[2]), .contention_seen(cs[2]),
               .mismatch_cnt(cnt2));
   cmos_bf #(.STUCK_OPEN(6'b000100), .CNT_W(4)) u3 (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .Y(y[3]),
               .y_q(yq[3]), .pun_on(pun[3]), .pdn_on(pdn[3]), .float_seen(fs[3]), .contention_seen(cs[3]),
               .mismatch_cnt(cnt3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] dut_cnt(input int k);
      return k == 0 ? 32'(cnt0) : k == 1 ? 32'(cnt1) : k == 2 ? 32'(cnt2) : 32'(cnt3);
   endfunction

   // each of the six devices: gate input A/B/C, NMOS for index<3, PMOS otherwise
   task automatic comb_update();
      logic [5:0] cond;
      logic g;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 6; i++) begin
            g = (i % 3 == 0) ? A : (i % 3 == 1) ? B : C;
            cond[i] = OPN[k][i] ? 1'b0 : SON[k][i] ? 1'b1 : (i < 3 ? g : !g);
         end
         m_pd[k] = (cond[0] && cond[1]) || cond[2];
         m_pu[k] = cond[5] && (cond[3] || cond[4]);
         if (m_pd[k]) m_hold[k] = 1'b0;
         else if (m_pu[k]) m_hold[k] = 1'b1;
         else if (!rst_n) m_hold[k] = 1'b0;
         m_y[k] = m_hold[k];
      end
   endtask

   task automatic comb_check();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("Y%0d", k), 32'(y[k]), 32'(m_y[k]));
         chk($sformatf("pun%0d", k), 32'(pun[k]), 32'(m_pu[k]));
         chk($sformatf("pdn%0d", k), 32'(pdn[k]), 32'(m_pd[k]));
      end
   endtask

   task automatic reg_update();
      logic gold;
      gold = !((A && B) || C);
      for (int k = 0; k < 4; k++) begin
         m_yq[k] = m_y[k];
         if (!m_pu[k] && !m_pd[k]) m_fs[k] = 1'b1;
         if (m_pu[k] && m_pd[k]) m_cs[k] = 1'b1;
         if (m_y[k] != gold && m_cnt[k] < MAXC[k]) m_cnt[k]++;
      end
   endtask

   task automatic reg_reset();
      for (int k = 0; k < 4; k++) begin
         m_yq[k] = 0; m_fs[k] = 0; m_cs[k] = 0; m_cnt[k] = 0;
      end
   endtask

   task automatic reg_check();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("y_q%0d", k), 32'(yq[k]), 32'(m_yq[k]));
         chk($sformatf("float%0d", k), 32'(fs[k]), 32'(m_fs[k]));
         chk($sformatf("cont%0d", k), 32'(cs[k]), 32'(m_cs[k]));
         chk($sformatf("cnt%0d", k), dut_cnt(k), 32'(m_cnt[k]));
      end
   endtask

   task automatic step(input logic [2:0] abc);
      @(negedge clk);
      {A, B, C} = abc;
      #1;
      comb_update();
      comb_check();
      @(posedge clk);
      reg_update();
      #1;
      reg_check();
   endtask

   initial begin
      logic [7:0] tt;
      tests = 0; fails = 0;
      for (int k = 0; k < 4; k++) m_hold[k] = 1'b0;
      reg_reset();
      rst_n = 1'b0; {A, B, C} = 3'b000;
      #3;
      comb_update();
      comb_check();
      reg_check();
      @(negedge clk);
      rst_n = 1'b1;
      tt = 8'b1010_1000;
      for (int v = 0; v < 8; v++) begin
         step(3'(v));
         chk($sformatf("truth%0d", v), 32'(y[0]), 32'(tt[7-v]));
      end
      step(3'b000);
      repeat (3) step(3'b001);
      step(3'b110);
      repeat (60) step(3'($urandom_range(0, 7)));
      step(3'b000);
      step(3'b001);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      comb_update();
      reg_reset();
      comb_check();
      reg_check();
      chk("float_rst", 32'(y[1]), 32'h0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      reg_update();
      #1;
      reg_check();
      step(3'b000);
      repeat (20) step(3'b001);
      chk("sat", 32'(cnt3), 32'hF);
      repeat (3) step(3'b001);
      chk("sat_hold", 32'(cnt3), 32'hF);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
